// File: rtl/spi_modport.sv
// SPI slave (mode 0) sampled entirely in the system clock domain. Word length, slave-select bit and shift order are parameters.
// Words stream back-to-back while selected; deselect in mid-word pulses abort.
module spi_modport #(
  parameter int DATA_W    = 32,
  parameter int SS_BIT    = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        ss_pad_o,
  input  logic              s_clk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              abort
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q;
  logic [1:0]          ss_q;
  logic [2:0]          sclk_q;
  logic [1:0]          mosi_q;
  logic                armed_q;
  logic                reload_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [DATA_W-1:0]   tx_buf_q, tx_shift_q, rx_shift_q, rx_data_q;
  logic                rx_valid_q, abort_q;

  logic                sel_n, sclk_rise, sclk_fall, last_bit;
  logic [DATA_W-1:0]   rx_shift_d, tx_shift_d, tx_fill_d;
  logic                unused_ss;

  assign unused_ss  = ^ss_pad_o;
  assign sel_n      = ss_q[1];
  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
  assign last_bit   = (bit_cnt_q == CNT_W'(DATA_W-1));

  assign rx_shift_d = (LSB_FIRST != 0) ? {mosi_q[1], rx_shift_q[DATA_W-1:1]}
                                       : {rx_shift_q[DATA_W-2:0], mosi_q[1]};
  assign tx_shift_d = (LSB_FIRST != 0) ? {1'b0, tx_shift_q[DATA_W-1:1]}
                                       : {tx_shift_q[DATA_W-2:0], 1'b0};
  // A load landing on the same cycle as a reload goes straight into the shifter.
  assign tx_fill_d  = tx_load ? tx_data : tx_buf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ss_q       <= '0;
      sclk_q     <= '0;
      mosi_q     <= '0;
      armed_q    <= 1'b0;
      reload_q   <= 1'b0;
      bit_cnt_q  <= '0;
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      ss_q       <= {ss_q[0], ss_pad_o[SS_BIT]};
      sclk_q     <= {sclk_q[1:0], s_clk};
      mosi_q     <= {mosi_q[0], mosi};
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      if (tx_load) tx_buf_q <= tx_data;
      // The synchronizer resets to "selected"; require a high select first so reset never restarts a transfer.
      if (sel_n) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (armed_q && !sel_n) begin
            state_q    <= ACTIVE;
            tx_shift_q <= tx_fill_d;
            bit_cnt_q  <= '0;
            reload_q   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            rx_shift_q <= rx_shift_d;
            if (last_bit) begin
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
              bit_cnt_q  <= '0;
              reload_q   <= 1'b1;
            end else begin
              bit_cnt_q  <= bit_cnt_q + 1'b1;
            end
          end
          if (sclk_fall) begin
            if (reload_q) begin
              tx_shift_q <= tx_fill_d;
              reload_q   <= 1'b0;
            end else if (bit_cnt_q != '0) begin
              tx_shift_q <= tx_shift_d;
            end
          end
          if (sel_n) begin
            state_q <= IDLE;
            if (!(sclk_rise && last_bit) && bit_cnt_q != '0) abort_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso     = (state_q == ACTIVE) ? ((LSB_FIRST != 0) ? tx_shift_q[0] : tx_shift_q[DATA_W-1]) : 1'b0;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_spi_modport.sv
// Bench for spi_modport: a 32-bit MSB-first slave and an 8-bit LSB-first slave driven by a task-level SPI master.
// Expected received words go into a queue at stimulus time and are matched against words captured on rx_valid.
module tb_spi_modport;
  localparam int HALF = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ss = 8'hFF, ss2 = 8'hFF;
  logic        s_clk = 1'b0, mosi = 1'b0;
  logic        miso, miso2;
  logic [31:0] tx_data = '0;
  logic        tx_load = 1'b0;
  logic [7:0]  tx2 = '0;
  logic        tx_load2 = 1'b0;
  logic [31:0] rx_data;
  logic [7:0]  rx_data2;
  logic        rx_valid, abort, rx_valid2, abort2;

  int n_checks = 0, n_fail = 0;
  int n_rxv = 0, n_abort = 0, n_rxv2 = 0, n_abort2 = 0;
  logic [31:0] exp_q[$], obs_q[$];
  logic [7:0]  obs2_q[$];

  spi_modport #(.DATA_W(32), .SS_BIT(0), .LSB_FIRST(0)) u_dut (
    .clock(clock), .reset(reset), .ss_pad_o(ss), .s_clk(s_clk), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid), .abort(abort));

  spi_modport #(.DATA_W(8), .SS_BIT(0), .LSB_FIRST(1)) u_dut_lsb (
    .clock(clock), .reset(reset), .ss_pad_o(ss2), .s_clk(s_clk), .mosi(mosi), .miso(miso2),
    .tx_data(tx2), .tx_load(tx_load2), .rx_data(rx_data2), .rx_valid(rx_valid2), .abort(abort2));

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid)  begin n_rxv++;  obs_q.push_back(rx_data);   end
    if (abort)     n_abort++;
    if (rx_valid2) begin n_rxv2++; obs2_q.push_back(rx_data2); end
    if (abort2)    n_abort2++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Master: mosi changes with the falling edge, miso is sampled just before the rising edge.
  task automatic xfer(input int nbits, input logic [31:0] mo, input bit use2,
                      input int load_at, input logic [31:0] load_val, output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[nbits-1-i];
      if (i == load_at) begin
        tx_data = load_val; tx_load = 1'b1; cyc(1); tx_load = 1'b0; cyc(HALF-1);
      end else begin
        cyc(HALF);
      end
      mi = {mi[30:0], use2 ? miso2 : miso};
      s_clk = 1'b1; cyc(HALF); s_clk = 1'b0;
    end
  endtask

  task automatic load1(input logic [31:0] v);
    tx_data = v; tx_load = 1'b1; cyc(1); tx_load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cyc(3);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", miso); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", abort); end
    n_checks++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
    n_checks++; if (rx_data2 !== 8'h0) begin n_fail++; $display("FAIL reset_rx_data2: got %h want 0", rx_data2); end
    reset = 1'b0; cyc(4);
  endtask

  task automatic test_basic;
    int v0, a0; logic [31:0] mi, e, g;
    v0 = n_rxv; a0 = n_abort;
    load1(32'hA5A5F00F);
    ss[0] = 1'b0; cyc(6);
    exp_q.push_back(32'h12345678);
    xfer(32, 32'h12345678, 0, -1, 32'h0, mi);
    cyc(HALF); ss[0] = 1'b1; cyc(6);
    n_checks++; if (mi !== 32'hA5A5F00F) begin n_fail++; $display("FAIL basic_miso: got %h want a5a5f00f", mi); end
    n_checks++; if (n_rxv - v0 != 1) begin n_fail++; $display("FAIL basic_rxv_count: got %0d want 1", n_rxv - v0); end
    n_checks++; if (n_abort - a0 != 0) begin n_fail++; $display("FAIL basic_abort_count: got %0d want 0", n_abort - a0); end
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() == 0) begin n_fail++; $display("FAIL basic_rx: got none want %h", e); end
    else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL basic_rx: got %h want %h", g, e); end end
    n_checks++; if (rx_data !== 32'h12345678) begin n_fail++; $display("FAIL basic_rx_data: got %h want 12345678", rx_data); end
  endtask

  task automatic test_back_to_back;
    int v0, a0; logic [31:0] mi1, mi2, e, g;
    v0 = n_rxv; a0 = n_abort;
    load1(32'hCAFEBABE);
    ss[0] = 1'b0; cyc(6);
    exp_q.push_back(32'h0F1E2D3C);
    exp_q.push_back(32'h87654321);
    xfer(32, 32'h0F1E2D3C, 0, 10, 32'h0000FFFF, mi1);
    xfer(32, 32'h87654321, 0, -1, 32'h0, mi2);
    cyc(HALF); ss[0] = 1'b1; cyc(6);
    n_checks++; if (mi1 !== 32'hCAFEBABE) begin n_fail++; $display("FAIL b2b_miso_w1: got %h want cafebabe", mi1); end
    n_checks++; if (mi2 !== 32'h0000FFFF) begin n_fail++; $display("FAIL b2b_miso_w2: got %h want 0000ffff", mi2); end
    n_checks++; if (n_rxv - v0 != 2) begin n_fail++; $display("FAIL b2b_rxv_count: got %0d want 2", n_rxv - v0); end
    n_checks++; if (n_abort - a0 != 0) begin n_fail++; $display("FAIL b2b_abort_count: got %0d want 0", n_abort - a0); end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_rx%0d: got none want %h", k, e); end
      else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL b2b_rx%0d: got %h want %h", k, g, e); end end
    end
  endtask

  task automatic test_abort;
    int v0, a0; logic [31:0] mi;
    v0 = n_rxv; a0 = n_abort;
    ss[0] = 1'b0; cyc(6);
    xfer(10, 32'h2AB, 0, -1, 32'h0, mi);
    ss[0] = 1'b1; cyc(6);
    n_checks++; if (n_abort - a0 != 1) begin n_fail++; $display("FAIL abort_count: got %0d want 1", n_abort - a0); end
    n_checks++; if (n_rxv - v0 != 0) begin n_fail++; $display("FAIL abort_rxv_count: got %0d want 0", n_rxv - v0); end
    n_checks++; if (rx_data !== 32'h87654321) begin n_fail++; $display("FAIL abort_rx_kept: got %h want 87654321", rx_data); end
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL abort_idle_miso: got %b want 0", miso); end
  endtask

  task automatic test_deselect_on_last;
    int v0, a0; logic [31:0] mi, w, e, g;
    v0 = n_rxv; a0 = n_abort; w = 32'hF0F0F0F1;
    load1(32'h5A5A5A5A);
    ss[0] = 1'b0; cyc(6);
    exp_q.push_back(w);
    xfer(31, w >> 1, 0, -1, 32'h0, mi);
    mosi = w[0]; cyc(HALF);
    s_clk = 1'b1; ss[0] = 1'b1; cyc(HALF); s_clk = 1'b0; cyc(6);
    n_checks++; if (n_rxv - v0 != 1) begin n_fail++; $display("FAIL deslast_rxv_count: got %0d want 1", n_rxv - v0); end
    n_checks++; if (n_abort - a0 != 0) begin n_fail++; $display("FAIL deslast_abort_count: got %0d want 0", n_abort - a0); end
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() == 0) begin n_fail++; $display("FAIL deslast_rx: got none want %h", e); end
    else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL deslast_rx: got %h want %h", g, e); end end
  endtask

  task automatic test_lsb;
    int v0, a0, v1; logic [31:0] mi; logic [7:0] g;
    v0 = n_rxv2; a0 = n_abort2; v1 = n_rxv;
    tx2 = 8'h96; tx_load2 = 1'b1; cyc(1); tx_load2 = 1'b0;
    ss2[0] = 1'b0; cyc(6);
    xfer(8, 32'h80, 1, -1, 32'h0, mi);
    cyc(HALF); ss2[0] = 1'b1; cyc(6);
    n_checks++; if (rx_data2 !== 8'h01) begin n_fail++; $display("FAIL lsb_rx_data: got %h want 01", rx_data2); end
    n_checks++; if (mi[7:0] !== 8'h69) begin n_fail++; $display("FAIL lsb_miso: got %h want 69", mi[7:0]); end
    n_checks++; if (n_rxv2 - v0 != 1) begin n_fail++; $display("FAIL lsb_rxv_count: got %0d want 1", n_rxv2 - v0); end
    n_checks++; if (n_abort2 - a0 != 0) begin n_fail++; $display("FAIL lsb_abort_count: got %0d want 0", n_abort2 - a0); end
    n_checks++;
    if (obs2_q.size() == 0) begin n_fail++; $display("FAIL lsb_rx_q: got none want 01"); end
    else begin g = obs2_q.pop_front(); if (g !== 8'h01) begin n_fail++; $display("FAIL lsb_rx_q: got %h want 01", g); end end
    n_checks++; if (n_rxv - v1 != 0) begin n_fail++; $display("FAIL lsb_other_slave_rxv: got %0d want 0", n_rxv - v1); end
  endtask

  task automatic test_other_ss;
    int v0, a0; logic [31:0] mi;
    v0 = n_rxv; a0 = n_abort;
    ss = 8'hFF; ss[3] = 1'b0;
    xfer(16, 32'hFFFF, 0, -1, 32'h0, mi);
    ss[3] = 1'b1; cyc(2); ss[3] = 1'b0; cyc(2);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL otherss_miso_now: got %b want 0", miso); end
    ss[3] = 1'b1; cyc(6);
    n_checks++; if (mi[15:0] !== 16'h0) begin n_fail++; $display("FAIL otherss_miso: got %h want 0000", mi[15:0]); end
    n_checks++; if (n_rxv - v0 != 0) begin n_fail++; $display("FAIL otherss_rxv_count: got %0d want 0", n_rxv - v0); end
    n_checks++; if (n_abort - a0 != 0) begin n_fail++; $display("FAIL otherss_abort_count: got %0d want 0", n_abort - a0); end
  endtask

  task automatic test_reset_mid;
    int v0, a0; logic [31:0] mi, e, g;
    a0 = n_abort;
    load1(32'h13579BDF);
    ss[0] = 1'b0; cyc(6);
    xfer(16, 32'hABCD, 0, -1, 32'h0, mi);
    reset = 1'b1; cyc(1);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso: got %b want 0", miso); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort: got %b want 0", abort); end
    n_checks++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_rx_data: got %h want 0", rx_data); end
    reset = 1'b0; cyc(6);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rstmid_stay_idle: got %b want 0", miso); end
    n_checks++; if (n_abort - a0 != 0) begin n_fail++; $display("FAIL rstmid_silent: got %0d want 0", n_abort - a0); end
    ss[0] = 1'b1; cyc(4);
    v0 = n_rxv;
    load1(32'h2468ACE0);
    ss[0] = 1'b0; cyc(6);
    exp_q.push_back(32'hDEADBEEF);
    xfer(32, 32'hDEADBEEF, 0, -1, 32'h0, mi);
    cyc(HALF); ss[0] = 1'b1; cyc(6);
    n_checks++; if (mi !== 32'h2468ACE0) begin n_fail++; $display("FAIL rstmid_fresh_miso: got %h want 2468ace0", mi); end
    n_checks++; if (n_rxv - v0 != 1) begin n_fail++; $display("FAIL rstmid_fresh_rxv: got %0d want 1", n_rxv - v0); end
    e = exp_q.pop_front();
    n_checks++;
    if (obs_q.size() == 0) begin n_fail++; $display("FAIL rstmid_fresh_rx: got none want %h", e); end
    else begin g = obs_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL rstmid_fresh_rx: got %h want %h", g, e); end end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_deselect_on_last();
    test_lsb();
    test_other_ss();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_modport.md
SPI_MODPORT -- requirements
Module: spi_modport

Interface
REQ-001 Parameter DATA_W, default 32, sets the word length in bits; legal range is 8..32.
REQ-002 Parameter SS_BIT, default 0, selects the index into ss_pad_o that addresses this slave.
REQ-003 Parameter LSB_FIRST, default 0, sets shift order on both lines (0 = MSB first).
REQ-004 Port clock  in  1  is the single system clock; all logic is on its rising edge.
REQ-005 Port reset  in  1  is the reset: synchronous, active-high.
REQ-006 Port ss_pad_o  in  8  carries the active-low slave selects from the SPI master; only bit SS_BIT is used.
REQ-007 Port s_clk  in  1  is the SPI serial clock; it idles low.
REQ-008 Port mosi  in  1  is serial data from the master.
REQ-009 Port miso  out  1  is serial data to the master.
REQ-010 Port tx_data  in  DATA_W  is the next word to transmit.
REQ-011 Port tx_load  in  1  writes tx_data into the transmit buffer when high.
REQ-012 Port rx_data  out  DATA_W  holds the last complete received word.
REQ-013 Port rx_valid  out  1  is a one-cycle pulse marking a new rx_data value.
REQ-014 Port abort  out  1  is a one-cycle pulse marking deselection in mid-word.

Function
REQ-015 ss_pad_o[SS_BIT], s_clk and mosi shall each pass through a 2-flop synchronizer; s_clk edges are detected from synchronized stage 2 versus a delayed stage 3.
REQ-016 The master shall hold s_clk high and low for at least 3 clock periods each; faster s_clk is out of scope.
REQ-017 The FSM shall have states IDLE and ACTIVE: IDLE -> ACTIVE when synchronized select is low; ACTIVE -> IDLE when it is high.
REQ-018 On IDLE -> ACTIVE: tx_shift <= tx_buf and bit_cnt <= 0.
REQ-019 While ACTIVE, miso shall present tx_shift[DATA_W-1] (or tx_shift[0] if LSB_FIRST) combinationally from the register.
REQ-020 While IDLE, miso shall be 0.
REQ-021 On a detected s_clk rising edge in ACTIVE: rx_shift shifts in synchronized mosi, and bit_cnt increments.
REQ-022 On a detected s_clk falling edge in ACTIVE with bit_cnt != 0: tx_shift shifts by one and fills with 0.
REQ-023 Falling edges with bit_cnt == 0 shall be ignored.
REQ-024 When the rising edge that completes bit DATA_W is processed, in the same cycle: rx_data <= the completed word including that bit, and rx_valid = 1 for exactly that one cycle.
REQ-025 In that same cycle: bit_cnt <= 0, and tx_shift <= tx_buf on the following falling edge, so words stream back-to-back while selected.
REQ-026 MSB-first mode: the first received bit lands in rx_data[DATA_W-1] and the first transmitted bit is tx_buf[DATA_W-1]; LSB-first mode mirrors both.
REQ-027 tx_load writes tx_buf at any time; the new value takes effect only at the next select or word boundary, never on the word in progress.
REQ-028 tx_load coinciding with a word-boundary reload shall forward the new tx_data into tx_shift.
REQ-029 Deselect with 0 < bit_cnt < DATA_W: abort pulses 1 cycle, the partial word is discarded, and rx_data is unchanged.
REQ-030 Deselect coinciding with the word-completing rising edge shall yield rx_valid and no abort.
REQ-031 ss_pad_o bits other than SS_BIT shall have no effect.
REQ-032 Reset mid-transfer aborts silently: no abort pulse, and the block stays IDLE until select is seen low again after reset is released.

Reset
REQ-033 Reset shall clear all of the following to 0: state=IDLE, tx_buf, tx_shift, rx_shift, bit_cnt, rx_data, rx_valid, abort, miso, and the synchronizer flops.

Verification
REQ-034 Reset, then tx_load with 0xA5A5F00F, select, 32 s_clk cycles with mosi = 0x12345678 MSB-first -> miso bits form 0xA5A5F00F; one rx_valid pulse; rx_data = 0x12345678.
REQ-035 Select held for 64 bits, with tx_load 0x0000FFFF written during word 1 -> word 1 still returns the original tx_buf; word 2 returns 0x0000FFFF; two rx_valid pulses.
REQ-036 Deselect after 10 bits -> abort pulses once, no rx_valid, and rx_data retains its prior value.
REQ-037 LSB_FIRST=1, DATA_W=8, mosi bits 1,0,0,0,0,0,0,0 -> rx_data = 0x01.
REQ-038 Toggle ss_pad_o[3] only, with s_clk running -> miso = 0, and no rx_valid or abort.
REQ-039 Assert reset at bit 16 -> outputs are 0 next cycle; a fresh select then transfers a complete word correctly.
